// File: rtl/lcd_bus_decoder_if.sv
// 8080-style LCD write bus: active-low write strobe, data/command select, 8-bit data.
interface lcd_bus_decoder_if;
  logic       wr;
  logic       dcx;
  logic [7:0] D;

  modport master (output wr, output dcx, output D);
  modport slave  (input  wr, input  dcx, input  D);
endinterface

// File: rtl/lcd_bus_decoder.sv
// Receive side of the 8080 LCD write bus: decodes an ILI9341 command subset into
// window registers, panel flags and a pixel stream tagged with absolute coordinates.
module lcd_bus_decoder #(
  parameter int unsigned COORD_W = 9,
  parameter int unsigned MAX_X   = 319,
  parameter int unsigned MAX_Y   = 239
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_bus_decoder_if.slave     bus,
  output logic                 pix_valid,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic [15:0]          pix_rgb,
  output logic                 frame_done,
  output logic                 disp_on,
  output logic                 sleep_out,
  output logic                 win_err
);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(MAX_Y);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_SKIP
  } state_t;

  state_t               state_q, state_d;
  logic                 wr_q;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [23:0]          param_q, param_d;
  logic [7:0]           rgb_hi_q, rgb_hi_d;
  logic [COORD_W-1:0]   sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [COORD_W-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]          pix_rgb_q, pix_rgb_d;
  logic                 frame_done_q, frame_done_d;
  logic                 disp_on_q, disp_on_d;
  logic                 sleep_out_q, sleep_out_d;
  logic                 win_err_q, win_err_d;

  logic                 byte_ev;
  logic [COORD_W-1:0]   start_v, end_v, max_v;

  assign byte_ev = bus.wr & ~wr_q;

  // Candidate window on the 4th CASET/PASET parameter byte.
  assign start_v = COORD_W'(param_q[23:8]);
  assign end_v   = COORD_W'({param_q[7:0], bus.D});
  assign max_v   = (state_q == ST_CASET) ? MAX_X_C : MAX_Y_C;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    param_d      = param_q;
    rgb_hi_d     = rgb_hi_q;
    sc_d         = sc_q;
    ec_d         = ec_q;
    sp_d         = sp_q;
    ep_d         = ep_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    frame_done_d = 1'b0;
    disp_on_d    = disp_on_q;
    sleep_out_d  = sleep_out_q;
    win_err_d    = 1'b0;

    if (byte_ev && !bus.dcx) begin
      // A command byte always aborts whatever sequence was in progress.
      byte_cnt_d = 2'd0;
      state_d    = ST_IDLE;
      unique case (bus.D)
        CMD_SWRESET: begin
          disp_on_d   = 1'b0;
          sleep_out_d = 1'b0;
        end
        CMD_SLPIN:   sleep_out_d = 1'b0;
        CMD_SLPOUT:  sleep_out_d = 1'b1;
        CMD_DISPOFF: disp_on_d   = 1'b0;
        CMD_DISPON:  disp_on_d   = 1'b1;
        CMD_CASET:   state_d     = ST_CASET;
        CMD_PASET:   state_d     = ST_PASET;
        CMD_RAMWR: begin
          state_d = ST_RAMWR;
          cur_x_d = sc_q;
          cur_y_d = sp_q;
        end
        default:     state_d     = ST_SKIP;
      endcase
    end else if (byte_ev) begin
      unique case (state_q)
        ST_CASET, ST_PASET: begin
          if (byte_cnt_q != 2'd3) begin
            param_d    = {param_q[15:0], bus.D};
            byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          end else begin
            byte_cnt_d = 2'd0;
            state_d    = ST_IDLE;
            if ((start_v > end_v) || (end_v > max_v)) begin
              win_err_d = 1'b1;
            end else if (state_q == ST_CASET) begin
              sc_d = start_v;
              ec_d = end_v;
            end else begin
              sp_d = start_v;
              ep_d = end_v;
            end
          end
        end
        ST_RAMWR: begin
          if (!byte_cnt_q[0]) begin
            rgb_hi_d   = bus.D;
            byte_cnt_d = 2'd1;
          end else begin
            byte_cnt_d  = 2'd0;
            pix_valid_d = 1'b1;
            pix_x_d     = cur_x_q;
            pix_y_d     = cur_y_q;
            pix_rgb_d   = {rgb_hi_q, bus.D};
            // Raster advance; the last window pixel wraps back to the origin.
            if (cur_x_q < ec_q) begin
              cur_x_d = COORD_W'(cur_x_q + 1'b1);
            end else if (cur_y_q < ep_q) begin
              cur_x_d = sc_q;
              cur_y_d = COORD_W'(cur_y_q + 1'b1);
            end else begin
              frame_done_d = 1'b1;
              cur_x_d      = sc_q;
              cur_y_d      = sp_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_q <= bus.wr;
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 2'd0;
      param_q      <= 24'd0;
      rgb_hi_q     <= 8'd0;
      sc_q         <= '0;
      ec_q         <= MAX_X_C;
      sp_q         <= '0;
      ep_q         <= MAX_Y_C;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= 16'd0;
      frame_done_q <= 1'b0;
      disp_on_q    <= 1'b0;
      sleep_out_q  <= 1'b0;
      win_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      param_q      <= param_d;
      rgb_hi_q     <= rgb_hi_d;
      sc_q         <= sc_d;
      ec_q         <= ec_d;
      sp_q         <= sp_d;
      ep_q         <= ep_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
      disp_on_q    <= disp_on_d;
      sleep_out_q  <= sleep_out_d;
      win_err_q    <= win_err_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign disp_on    = disp_on_q;
  assign sleep_out  = sleep_out_q;
  assign win_err    = win_err_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: directed scenarios plus random bus traffic against a
// window/pixel-index reference model.
module tb_lcd_bus_decoder;
  localparam int unsigned COORD_W = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               pix_valid, frame_done, disp_on, sleep_out, win_err;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [15:0]        pix_rgb;

  lcd_bus_decoder_if bus ();

  lcd_bus_decoder #(.COORD_W(COORD_W), .MAX_X(319), .MAX_Y(239)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .disp_on(disp_on), .sleep_out(sleep_out), .win_err(win_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 caset, 2 paset, 3 ramwr, 4 skip.
  int   m_mode, m_np, m_sc, m_ec, m_sp, m_ep, m_k;
  int   m_pb [4];
  bit   m_half, m_disp, m_sleep;
  int   m_hi, m_lx, m_ly, m_lrgb;
  bit   e_pv, e_fd, e_we;

  task automatic model_reset();
    m_mode = 0; m_np = 0; m_half = 0; m_k = 0; m_hi = 0;
    m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
    m_disp = 0; m_sleep = 0; m_lx = 0; m_ly = 0; m_lrgb = 0;
  endtask

  task automatic model_byte(input bit dc, input int b);
    int s, e, mx, w, h, idx;
    e_pv = 0; e_fd = 0; e_we = 0;
    if (!dc) begin
      m_np = 0; m_half = 0; m_mode = 0;
      case (b)
        'h01: begin m_disp = 0; m_sleep = 0; end
        'h10: m_sleep = 0;
        'h11: m_sleep = 1;
        'h28: m_disp = 0;
        'h29: m_disp = 1;
        'h2A: m_mode = 1;
        'h2B: m_mode = 2;
        'h2C: begin m_mode = 3; m_k = 0; end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_pb[m_np] = b;
      m_np++;
      if (m_np == 4) begin
        s  = (m_pb[0] * 256 + m_pb[1]) % 512;
        e  = (m_pb[2] * 256 + m_pb[3]) % 512;
        mx = (m_mode == 1) ? 319 : 239;
        if (s > e || e > mx) e_we = 1;
        else if (m_mode == 1) begin m_sc = s; m_ec = e; end
        else begin m_sp = s; m_ep = e; end
        m_mode = 0; m_np = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_half) begin
        m_hi = b; m_half = 1;
      end else begin
        m_half = 0;
        w   = m_ec - m_sc + 1;
        h   = m_ep - m_sp + 1;
        idx = m_k % (w * h);
        m_lx = m_sc + idx % w;
        m_ly = m_sp + idx / w;
        m_lrgb = m_hi * 256 + b;
        e_pv = 1;
        e_fd = (idx == w * h - 1);
        m_k++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".pix_valid"},  32'(pix_valid),  32'(e_pv));
    check_eq({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    check_eq({tag, ".win_err"},    32'(win_err),    32'(e_we));
    check_eq({tag, ".disp_on"},    32'(disp_on),    32'(m_disp));
    check_eq({tag, ".sleep_out"},  32'(sleep_out),  32'(m_sleep));
    check_eq({tag, ".pix_x"},      32'(pix_x),      32'(m_lx));
    check_eq({tag, ".pix_y"},      32'(pix_y),      32'(m_ly));
    check_eq({tag, ".pix_rgb"},    32'(pix_rgb),    32'(m_lrgb));
  endtask

  // One write: wr low for a cycle, high again; outputs checked one clock after the event.
  task automatic send_byte(input bit dc, input logic [7:0] b);
    @(negedge clk);
    check_eq("pulse_idle", 32'({pix_valid, frame_done, win_err}), 32'd0);
    bus.wr = 1'b0; bus.dcx = dc; bus.D = b;
    @(negedge clk);
    check_eq("no_early_pulse", 32'({pix_valid, frame_done, win_err}), 32'd0);
    bus.wr = 1'b1;
    model_byte(dc, int'(b));
    @(negedge clk);
    check_outputs(dc ? "data" : "cmd");
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    send_byte(1'b0, c);
  endtask

  task automatic send_win(input logic [7:0] c, input int s, input int e);
    send_cmd(c);
    send_byte(1'b1, 8'(s >> 8)); send_byte(1'b1, 8'(s));
    send_byte(1'b1, 8'(e >> 8)); send_byte(1'b1, 8'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.wr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    e_pv = 0; e_fd = 0; e_we = 0;
    check_outputs("reset");
  endtask

  initial begin
    int r, n;
    rst = 1'b1; bus.wr = 1'b1; bus.dcx = 1'b1; bus.D = 8'h00;
    model_reset();
    do_reset();

    // Default window: pixels at (0,0),(1,0).
    send_cmd(8'h2C);
    send_byte(1, 8'hF8); send_byte(1, 8'h00); send_byte(1, 8'h07); send_byte(1, 8'hE0);

    // 3x2 window at (1,2); 8 pixels wrap after the 6th.
    send_win(8'h2A, 1, 3);
    send_win(8'h2B, 2, 3);
    send_cmd(8'h2C);
    for (int i = 0; i < 16; i++) send_byte(1, 8'($urandom));

    // Illegal window keeps old SC.
    send_win(8'h2A, 5, 2);
    send_win(8'h2B, 0, 240);
    send_cmd(8'h2C);
    send_byte(1, 8'h12); send_byte(1, 8'h34);

    // Half pixel discarded by a command.
    send_cmd(8'h2C); send_byte(1, 8'hAB); send_cmd(8'h29);
    send_cmd(8'h2C); send_byte(1, 8'h56); send_byte(1, 8'h78);

    // Partial CASET aborted by RAMWR.
    send_cmd(8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h10);
    send_cmd(8'h2C); send_byte(1, 8'h9A); send_byte(1, 8'hBC);

    // Flags.
    send_cmd(8'h29); send_cmd(8'h11); send_cmd(8'h01);
    send_cmd(8'h11); send_cmd(8'h10); send_cmd(8'h29); send_cmd(8'h28);

    // Reset after an odd byte; data alone then produces nothing.
    send_cmd(8'h2C);
    send_byte(1, 8'h11); send_byte(1, 8'h22); send_byte(1, 8'h33);
    do_reset();
    send_byte(1, 8'h44); send_byte(1, 8'h55);
    send_cmd(8'h2C); send_byte(1, 8'h66); send_byte(1, 8'h77);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 19));
      if (r < 4) begin
        n = int'($urandom_range(0, 300));
        send_win((r[0]) ? 8'h2A : 8'h2B, n, n + int'($urandom_range(0, 3)));
      end else if (r < 5) begin
        send_cmd(r[0] ? 8'h2A : 8'h2B);
        repeat ($urandom_range(0, 4)) send_byte(1, 8'($urandom));
      end else if (r < 11) begin
        send_cmd(8'h2C);
        repeat ($urandom_range(0, 24)) send_byte(1, 8'($urandom));
      end else if (r < 14) begin
        case ($urandom_range(0, 4))
          0: send_cmd(8'h01);
          1: send_cmd(8'h10);
          2: send_cmd(8'h11);
          3: send_cmd(8'h28);
          default: send_cmd(8'h29);
        endcase
      end else if (r < 16) begin
        send_cmd(8'($urandom));
        repeat ($urandom_range(0, 3)) send_byte(1, 8'($urandom));
      end else if (r < 19) begin
        repeat ($urandom_range(1, 3)) send_byte(1, 8'($urandom));
      end else begin
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
